// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the two-approach intersection controller.
//   - state_e   : 3-bit controller state encoding
//   - LED_*     : active-low {R,G,B} codes for one signal head
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_AR_TO_A  = 3'd0,
        ST_A_GREEN  = 3'd1,
        ST_A_YELLOW = 3'd2,
        ST_AR_TO_B  = 3'd3,
        ST_B_GREEN  = 3'd4,
        ST_B_YELLOW = 3'd5,
        ST_PED      = 3'd6,
        ST_FLASH    = 3'd7
    } state_e;

    // Active-low RGB: a 0 bit lights that colour.
    localparam logic [2:0] LED_RED    = 3'b011;
    localparam logic [2:0] LED_YELLOW = 3'b001;
    localparam logic [2:0] LED_GREEN  = 3'b101;
    localparam logic [2:0] LED_OFF    = 3'b111;

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen
//   Free-running divider producing a one-cycle pulse every millisecond.
//   Counts 0..CLK_FREQ/1000-1; TICK is high on the terminal count, after
//   which the counter wraps to 0.
// Ports:
//   CLK  in   system clock
//   RST  in   synchronous active-high reset, clears the divider
//   TICK out  1 ms strobe, one clock wide
module ms_tick_gen #(
    parameter int CLK_FREQ = 12000000
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);

    localparam int TC = CLK_FREQ / 1000;
    localparam int CW = $clog2(TC);
    localparam logic [CW-1:0] TC_LAST = CW'(TC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign TICK = (cnt_q == TC_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (TICK) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_intersection.sv
// traffic_intersection
//   Two-approach signal controller with all-red clearance, latched
//   pedestrian request and night flashing-yellow mode, timed by a 1 ms tick.
// Ports:
//   CLK          in   system clock
//   RST          in   synchronous active-high reset
//   PED_REQ      in   pedestrian button level; any high cycle latches a request
//   FLASH_MODE   in   1 = night flashing-yellow operation
//   CLED_A       out  approach A head, active-low {R,G,B}
//   CLED_B       out  approach B head, active-low {R,G,B}
//   PED_WALK     out  WALK lamp
//   PED_PENDING  out  request latched and not yet served
module traffic_intersection
    import traffic_pkg::*;
#(
    parameter int CLK_FREQ      = 12000000,
    parameter int G_PERIOD_MS   = 5000,
    parameter int Y_PERIOD_MS   = 1000,
    parameter int AR_PERIOD_MS  = 1000,
    parameter int PED_PERIOD_MS = 4000,
    parameter int BLINK_MS      = 500
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PED_REQ,
    input  logic       FLASH_MODE,
    output logic [2:0] CLED_A,
    output logic [2:0] CLED_B,
    output logic       PED_WALK,
    output logic       PED_PENDING
);

    localparam logic [31:0] G_LAST   = 32'(G_PERIOD_MS - 1);
    localparam logic [31:0] Y_LAST   = 32'(Y_PERIOD_MS - 1);
    localparam logic [31:0] AR_LAST  = 32'(AR_PERIOD_MS - 1);
    localparam logic [31:0] PED_LAST = 32'(PED_PERIOD_MS - 1);
    localparam logic [31:0] BL_LAST  = 32'(BLINK_MS - 1);

    logic        tick;
    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic        pending_q, pending_d;
    logic        phase_q, phase_d;
    logic        dest_b_q, dest_b_d;   // green deferred by PED: 0 = A, 1 = B
    logic        blink_wrap;
    logic        entering;
    logic [2:0]  led_a, led_b;
    logic        walk;

    ms_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (tick)
    );

    // Next-state logic. Every state leaves on the tick where timer hits its
    // last count, except green which also yields at once to FLASH_MODE.
    always_comb begin
        state_d    = state_q;
        dest_b_d   = dest_b_q;
        blink_wrap = 1'b0;
        case (state_q)
            ST_AR_TO_A: begin
                if (tick && timer_q == AR_LAST) begin
                    if (FLASH_MODE) begin
                        state_d = ST_FLASH;
                    end else if (pending_q) begin
                        state_d  = ST_PED;
                        dest_b_d = 1'b0;
                    end else begin
                        state_d = ST_A_GREEN;
                    end
                end
            end
            ST_A_GREEN: begin
                if (FLASH_MODE || (tick && timer_q == G_LAST)) state_d = ST_A_YELLOW;
            end
            ST_A_YELLOW: begin
                if (tick && timer_q == Y_LAST) state_d = ST_AR_TO_B;
            end
            ST_AR_TO_B: begin
                if (tick && timer_q == AR_LAST) begin
                    if (FLASH_MODE) begin
                        state_d = ST_FLASH;
                    end else if (pending_q) begin
                        state_d  = ST_PED;
                        dest_b_d = 1'b1;
                    end else begin
                        state_d = ST_B_GREEN;
                    end
                end
            end
            ST_B_GREEN: begin
                if (FLASH_MODE || (tick && timer_q == G_LAST)) state_d = ST_B_YELLOW;
            end
            ST_B_YELLOW: begin
                if (tick && timer_q == Y_LAST) state_d = ST_AR_TO_A;
            end
            ST_PED: begin
                if (tick && timer_q == PED_LAST) begin
                    state_d = dest_b_q ? ST_B_GREEN : ST_A_GREEN;
                end
            end
            ST_FLASH: begin
                if (!FLASH_MODE) begin
                    state_d = ST_AR_TO_A;
                end else if (tick && timer_q == BL_LAST) begin
                    // Timer is reused as the blink half-period counter.
                    blink_wrap = 1'b1;
                end
            end
            default: state_d = ST_AR_TO_A;
        endcase
    end

    assign entering = (state_d != state_q);

    always_comb begin
        timer_d = timer_q;
        if (entering || blink_wrap) begin
            timer_d = '0;
        end else if (tick) begin
            timer_d = timer_q + 32'd1;
        end

        phase_d = phase_q;
        if (entering && state_d == ST_FLASH) begin
            phase_d = 1'b1;
        end else if (blink_wrap) begin
            phase_d = ~phase_q;
        end

        // A request arriving on the very cycle PED is entered is served by
        // that PED, so the clear on entry wins.
        pending_d = pending_q | (PED_REQ && state_q != ST_PED);
        if (entering && state_d == ST_PED) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_AR_TO_A;
            timer_q   <= '0;
            pending_q <= 1'b0;
            phase_q   <= 1'b0;
            dest_b_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            phase_q   <= phase_d;
            dest_b_q  <= dest_b_d;
        end
    end

    // Output decode from registers only; unserved approaches default to red.
    always_comb begin
        led_a = LED_RED;
        led_b = LED_RED;
        walk  = 1'b0;
        case (state_q)
            ST_A_GREEN:  led_a = LED_GREEN;
            ST_A_YELLOW: led_a = LED_YELLOW;
            ST_B_GREEN:  led_b = LED_GREEN;
            ST_B_YELLOW: led_b = LED_YELLOW;
            ST_PED:      walk  = 1'b1;
            ST_FLASH: begin
                led_a = phase_q ? LED_YELLOW : LED_OFF;
                led_b = phase_q ? LED_YELLOW : LED_OFF;
            end
            default: ;
        endcase
    end

    assign CLED_A      = led_a;
    assign CLED_B      = led_b;
    assign PED_WALK    = walk;
    assign PED_PENDING = pending_q;

endmodule

// File: tb/tb_traffic_intersection.sv
// tb_traffic_intersection
//   Directed sequences with hand-computed per-cycle outputs pushed into an
//   expected queue, a monitor that pops and compares every cycle, an
//   output-level safety/duration checker, and a short random soak.
//   Timing: CLK_FREQ=4000 -> tick every 4 cycles; AR=4, G=20, Y=8, PED=12,
//   blink half-period 8 cycles.
module tb_traffic_intersection;

    localparam logic [2:0] RED = 3'b011;
    localparam logic [2:0] YEL = 3'b001;
    localparam logic [2:0] GRN = 3'b101;
    localparam logic [2:0] OFF = 3'b111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ped_req = 1'b0;
    logic       flash_mode = 1'b0;
    logic [2:0] cled_a, cled_b;
    logic       ped_walk, ped_pending;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic chk_on = 1'b0;

    traffic_intersection #(
        .CLK_FREQ      (4000),
        .G_PERIOD_MS   (5),
        .Y_PERIOD_MS   (2),
        .AR_PERIOD_MS  (1),
        .PED_PERIOD_MS (3),
        .BLINK_MS      (2)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .PED_REQ     (ped_req),
        .FLASH_MODE  (flash_mode),
        .CLED_A      (cled_a),
        .CLED_B      (cled_b),
        .PED_WALK    (ped_walk),
        .PED_PENDING (ped_pending)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    // Each step drives inputs on the falling edge and records the outputs
    // expected after the following rising edge.
    task automatic run(input int n, input logic [2:0] a, input logic [2:0] b,
                       input logic walk, input logic pend,
                       input logic req, input logic flash, input logic rst_v);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst        = rst_v;
            ped_req    = req;
            flash_mode = flash;
            @(posedge clk);
            exp_q.push_back({a, b, walk, pend});
        end
    endtask

    // One undisturbed cycle starting right after reset release. The reset
    // interval itself is the first of the four AR_TO_A cycles.
    task automatic normal_period();
        run(3,  RED, RED, 0, 0, 0, 0, 0);
        run(20, GRN, RED, 0, 0, 0, 0, 0);
        run(8,  YEL, RED, 0, 0, 0, 0, 0);
        run(4,  RED, RED, 0, 0, 0, 0, 0);
        run(20, RED, GRN, 0, 0, 0, 0, 0);
        run(8,  RED, YEL, 0, 0, 0, 0, 0);
        run(4,  RED, RED, 0, 0, 0, 0, 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic [7:0] e;
        logic [7:0] g;
        int idx;
        idx = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {cled_a, cled_b, ped_walk, ped_pending};
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL out#%0d got a=%b b=%b walk=%b pend=%b want a=%b b=%b walk=%b pend=%b",
                             idx, g[7:5], g[4:2], g[1], g[0], e[7:5], e[4:2], e[1], e[0]);
                end
                idx++;
            end
        end
    end

    // ---------------- safety / duration checker ----------------
    // Outside FLASH at least one head is red; FLASH shows both heads equal,
    // yellow or off. No output pattern may persist past the longest state.
    initial begin : safety
        logic [6:0] pat;
        logic [6:0] prev_pat;
        int run_len;
        prev_pat = 'x;
        run_len  = 0;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                pat = {cled_a, cled_b, ped_walk};
                if (pat === prev_pat) run_len++;
                else run_len = 1;
                prev_pat = pat;
                total++;
                if (run_len > 20) begin
                    bad++;
                    $display("FAIL runlen got=%0d max=20 pattern a=%b b=%b walk=%b",
                             run_len, cled_a, cled_b, ped_walk);
                end
                total++;
                if (cled_a !== RED && cled_b !== RED &&
                    !(cled_a === cled_b && (cled_a === YEL || cled_a === OFF) && ped_walk === 1'b0)) begin
                    bad++;
                    $display("FAIL conflict got a=%b b=%b walk=%b want one head red or flash pair",
                             cled_a, cled_b, ped_walk);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #1000000;
        bad++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        // Reset held: outputs red/red, no walk, nothing pending.
        run(3, RED, RED, 0, 0, 0, 0, 1);
        chk_on = 1'b1;

        // Plain cycle after reset release.
        normal_period();

        // Pedestrian pulse during A green; PED served after AR_TO_B,
        // PED_REQ during PED ignored, then the deferred B green.
        run(5,  GRN, RED, 0, 0, 0, 0, 0);
        run(1,  GRN, RED, 0, 1, 1, 0, 0);
        run(14, GRN, RED, 0, 1, 0, 0, 0);
        run(8,  YEL, RED, 0, 1, 0, 0, 0);
        run(4,  RED, RED, 0, 1, 0, 0, 0);
        run(3,  RED, RED, 1, 0, 0, 0, 0);
        run(2,  RED, RED, 1, 0, 1, 0, 0);
        run(7,  RED, RED, 1, 0, 0, 0, 0);
        run(20, RED, GRN, 0, 0, 0, 0, 0);
        run(8,  RED, YEL, 0, 0, 0, 0, 0);
        run(4,  RED, RED, 0, 0, 0, 0, 0);

        // FLASH_MODE raised on the 4th green cycle: full yellow, full AR,
        // then FLASH starting with yellow. A request latched on the way is
        // held through FLASH.
        run(4,  GRN, RED, 0, 0, 0, 0, 0);
        run(1,  YEL, RED, 0, 1, 1, 1, 0);
        run(7,  YEL, RED, 0, 1, 0, 1, 0);
        run(4,  RED, RED, 0, 1, 0, 1, 0);
        run(8,  YEL, YEL, 0, 1, 0, 1, 0);
        run(8,  OFF, OFF, 0, 1, 0, 1, 0);
        run(8,  YEL, YEL, 0, 1, 0, 1, 0);
        run(8,  OFF, OFF, 0, 1, 0, 1, 0);
        run(4,  YEL, YEL, 0, 1, 0, 1, 0);

        // FLASH_MODE dropped with a pending request: AR_TO_A, PED, A green.
        run(4,  RED, RED, 0, 1, 0, 0, 0);
        run(12, RED, RED, 1, 0, 0, 0, 0);
        run(4,  GRN, RED, 0, 0, 0, 0, 0);

        // Finish A green with a new request, reach PED, reset mid-PED.
        run(2,  GRN, RED, 0, 0, 0, 0, 0);
        run(1,  GRN, RED, 0, 1, 1, 0, 0);
        run(13, GRN, RED, 0, 1, 0, 0, 0);
        run(8,  YEL, RED, 0, 1, 0, 0, 0);
        run(4,  RED, RED, 0, 1, 0, 0, 0);
        run(5,  RED, RED, 1, 0, 0, 0, 0);
        run(2,  RED, RED, 0, 0, 0, 0, 1);
        normal_period();
        run(4,  GRN, RED, 0, 0, 0, 0, 0);

        // Random soak: only the safety/duration checker applies.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(299, 0) == 0) flash_mode = ~flash_mode;
            ped_req = ($urandom_range(39, 0) == 0);
            @(posedge clk);
        end

        @(negedge clk);
        ped_req    = 1'b0;
        flash_mode = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d entries left want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
